// File: rtl/mm_stream_host.sv
// Host-side driver for the matrix-multiplier stream: sends operands A then B,
// collects the result stream into a small buffer and reports status.
module mm_stream_host #(
    parameter int MAXD    = 4,
    parameter int DW      = 8,
    parameter int RW      = 12,
    parameter int BUSY_TO = 16,
    parameter int RUN_TO  = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [3:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic [2:0]    a_rows,
    input  logic [2:0]    a_cols,
    input  logic [2:0]    b_rows,
    input  logic [2:0]    b_cols,
    input  logic          start,
    output logic [DW-1:0] in_data,
    output logic          col_end,
    output logic          row_end,
    input  logic          mm_busy,
    input  logic          mm_valid,
    input  logic [RW-1:0] mm_out_data,
    input  logic          mm_is_legal,
    input  logic          mm_overflow,
    input  logic          mm_change_row,
    input  logic [3:0]    rd_addr,
    output logic [RW-1:0] rd_data,
    output logic          host_busy,
    output logic          done,
    output logic [4:0]    res_count,
    output logic [2:0]    rows_seen,
    output logic          illegal,
    output logic          ovf_seen,
    output logic          count_err,
    output logic          timeout
);

    localparam int DEPTH = MAXD * MAXD;
    localparam logic [7:0] BUSY_LAST = 8'(BUSY_TO - 1);
    localparam logic [7:0] RUN_LAST  = 8'(RUN_TO - 1);
    localparam logic [4:0] RES_FULL  = 5'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_A, S_SEND_B, S_WAIT, S_COLLECT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];
    logic [RW-1:0] res_mem [DEPTH];

    logic [2:0] ar_q, ac_q, br_q, bc_q;
    logic       sel_q;
    logic [2:0] r_q, c_q;
    logic [7:0] tcnt_q;
    logic       busy_q;

    logic       is_idle, streaming;
    logic [2:0] rows_a, cols_a, rows_b, cols_b;
    logic       nxt_act, nxt_sel;
    logic [2:0] nxt_r, nxt_c, nxt_rows, nxt_cols;
    logic       nxt_ce, nxt_re;
    logic [3:0] nxt_addr;
    logic [DW-1:0] nxt_data;

    logic       launch, collect_en, store, to_hit, enter_done, busy_fall;
    logic       illegal_d, ovf_d, timeout_d, cerr_d;
    logic [4:0] res_count_d;
    logic [2:0] rows_seen_d;
    logic [5:0] exp_cnt;

    assign is_idle    = (state_q == S_IDLE);
    assign streaming  = (state_q == S_SEND_A) || (state_q == S_SEND_B);
    assign launch     = is_idle && start;
    assign busy_fall  = busy_q && !mm_busy;
    assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

    // Next-state decode of the run sequencer
    always_comb begin
        state_d = state_q;
        to_hit  = 1'b0;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_SEND_A;
            S_SEND_A:  if (row_end) state_d = S_SEND_B;
            S_SEND_B:  if (row_end) state_d = S_WAIT;
            S_WAIT: begin
                if (mm_busy) begin
                    state_d = S_COLLECT;
                end else if (tcnt_q == BUSY_LAST) begin
                    state_d = S_DONE;
                    to_hit  = 1'b1;
                end
            end
            S_COLLECT: begin
                if (busy_fall) begin
                    state_d = S_DONE;
                end else if (tcnt_q == RUN_LAST) begin
                    state_d = S_DONE;
                    to_hit  = 1'b1;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Dimensions come straight from the ports on the launch cycle
    assign rows_a = is_idle ? a_rows : ar_q;
    assign cols_a = is_idle ? a_cols : ac_q;
    assign rows_b = is_idle ? b_rows : br_q;
    assign cols_b = is_idle ? b_cols : bc_q;

    // Pick the element to present next cycle and its end markers
    always_comb begin
        nxt_act = 1'b0;
        nxt_sel = 1'b0;
        nxt_r   = '0;
        nxt_c   = '0;
        unique case (1'b1)
            launch: nxt_act = 1'b1;
            streaming && row_end: begin
                nxt_act = !sel_q;
                nxt_sel = 1'b1;
            end
            streaming && col_end && !row_end: begin
                nxt_act = 1'b1;
                nxt_sel = sel_q;
                nxt_r   = r_q + 3'd1;
            end
            streaming && !col_end: begin
                nxt_act = 1'b1;
                nxt_sel = sel_q;
                nxt_r   = r_q;
                nxt_c   = c_q + 3'd1;
            end
            default: ;
        endcase
        nxt_rows = nxt_sel ? rows_b : rows_a;
        nxt_cols = nxt_sel ? cols_b : cols_a;
        nxt_ce   = nxt_act && (nxt_c == nxt_cols - 3'd1);
        nxt_re   = nxt_ce && (nxt_r == nxt_rows - 3'd1);
        nxt_addr = {nxt_r[1:0], nxt_c[1:0]};
        nxt_data = '0;
        if (nxt_act) nxt_data = nxt_sel ? mem_b[nxt_addr] : mem_a[nxt_addr];
    end

    // Result capture and sticky status, evaluated as next values
    always_comb begin
        collect_en  = mm_valid && ((state_q == S_WAIT) || (state_q == S_COLLECT));
        store       = collect_en && mm_is_legal;
        illegal_d   = illegal || (collect_en && !mm_is_legal);
        ovf_d       = ovf_seen || (store && mm_overflow);
        timeout_d   = timeout || to_hit;
        res_count_d = res_count;
        if (store && (res_count != RES_FULL)) res_count_d = res_count + 5'd1;
        rows_seen_d = rows_seen;
        if (collect_en && mm_change_row && (rows_seen != 3'd7))
            rows_seen_d = rows_seen + 3'd1;
        exp_cnt = {3'b000, ar_q} * {3'b000, bc_q};
        cerr_d  = count_err ||
                  (enter_done && !illegal_d && !timeout_d &&
                   ({1'b0, res_count_d} != exp_cnt));
    end

    // Operand and result storage, not reset
    always_ff @(posedge clk) begin
        if (is_idle && cfg_we) begin
            if (cfg_sel) mem_b[cfg_addr] <= cfg_wdata;
            else         mem_a[cfg_addr] <= cfg_wdata;
        end
        if (store && !res_count[4]) res_mem[res_count[3:0]] <= mm_out_data;
    end

    assign rd_data = res_mem[rd_addr];

    // Registered stream outputs, run counters and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_data   <= '0;
            col_end   <= 1'b0;
            row_end   <= 1'b0;
            sel_q     <= 1'b0;
            r_q       <= '0;
            c_q       <= '0;
            ar_q      <= '0;
            ac_q      <= '0;
            br_q      <= '0;
            bc_q      <= '0;
            tcnt_q    <= '0;
            busy_q    <= 1'b0;
            host_busy <= 1'b0;
            done      <= 1'b0;
            res_count <= '0;
            rows_seen <= '0;
            illegal   <= 1'b0;
            ovf_seen  <= 1'b0;
            count_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            in_data <= nxt_data;
            col_end <= nxt_ce;
            row_end <= nxt_re;
            sel_q   <= nxt_sel;
            r_q     <= nxt_r;
            c_q     <= nxt_c;
            busy_q  <= mm_busy;
            done    <= enter_done;
            if (state_d != state_q) tcnt_q <= '0;
            else                    tcnt_q <= tcnt_q + 8'd1;
            if (launch) begin
                ar_q      <= a_rows;
                ac_q      <= a_cols;
                br_q      <= b_rows;
                bc_q      <= b_cols;
                host_busy <= 1'b1;
                res_count <= '0;
                rows_seen <= '0;
                illegal   <= 1'b0;
                ovf_seen  <= 1'b0;
                count_err <= 1'b0;
                timeout   <= 1'b0;
            end else begin
                if (enter_done) host_busy <= 1'b0;
                res_count <= res_count_d;
                rows_seen <= rows_seen_d;
                illegal   <= illegal_d;
                ovf_seen  <= ovf_d;
                count_err <= cerr_d;
                timeout   <= timeout_d;
            end
        end
    end

endmodule

// File: doc/mm_stream_host.md
Name: mm_stream_host

Overview:
- Producer/consumer on the far side of the matrix-multiplier streaming interface.
- Holds two host-written operand matrices (up to 4x4, signed 8-bit) and streams them row-major on in_data with col_end/row_end markers, A then B back-to-back.
- Collects the multiplier's result stream (valid/out_data/change_row/is_legal/overflow) into a 16-entry result buffer, and reports completion and error status to the host.

Parameters:
- MAXD, 4, maximum rows/cols per matrix; storage depth MAXD*MAXD.
- DW, 8, operand width.
- RW, 12, result width.
- BUSY_TO, 16, cycles to wait for busy after the last B element.
- RUN_TO, 255, maximum COLLECT cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cfg_we  in  1  operand write strobe (IDLE only)
- cfg_sel  in  1  0=matrix A, 1=matrix B
- cfg_addr  in  4  element address r*MAXD+c
- cfg_wdata  in  8  operand value
- a_rows, a_cols, b_rows, b_cols  in  3 each  dimensions, 1..4; sampled at start
- start  in  1  launch pulse (IDLE only)
- in_data  out  8  operand stream to multiplier
- col_end  out  1  last element of current row
- row_end  out  1  last element of current matrix
- mm_busy  in  1  multiplier busy
- mm_valid  in  1  result valid
- mm_out_data  in  12  signed result
- mm_is_legal  in  1  multiplier legality flag
- mm_overflow  in  1  multiplier overflow flag
- mm_change_row  in  1  multiplier row-change flag
- rd_addr  in  4  result buffer read address
- rd_data  out  12  result buffer data (combinational read)
- host_busy  out  1  high from start until DONE
- done  out  1  one-cycle pulse on entering DONE
- res_count  out  5  results captured
- rows_seen  out  3  mm_change_row pulses counted
- illegal, ovf_seen, count_err, timeout  out  1 each  sticky status, cleared at start

Behaviour:
- Reset is asynchronous and active-high on rst; the clock is clk.
- Reset state: IDLE. All outputs and counters are 0. Operand and result memories are not reset.
- Operand writes: cfg_we is honoured only in IDLE. It writes mem[cfg_sel][cfg_addr].
- Start: start in IDLE latches the four dimensions, clears all status flags, res_count and rows_seen, and raises host_busy the next cycle. start outside IDLE is ignored.
- FSM states:
  - IDLE -> SEND_A on start.
  - SEND_A -> SEND_B after the a_rows*a_cols-th element.
  - SEND_B -> WAIT_BUSY after the b_rows*b_cols-th element.
  - WAIT_BUSY -> COLLECT when mm_busy=1. WAIT_BUSY -> DONE with timeout=1 after BUSY_TO cycles.
  - COLLECT -> DONE on the mm_busy 1->0 edge. COLLECT -> DONE with timeout=1 after RUN_TO cycles.
  - DONE -> IDLE after 1 cycle.
- Streaming:
  - Outputs are registered. The first A element is on in_data the cycle after start is sampled.
  - One element per cycle, with no gap between A and B.
  - Element (r,c) is read from address r*MAXD+c.
  - col_end=1 when c==cols-1.
  - row_end=1 when c==cols-1 and r==rows-1, so it always coincides with col_end.
  - Outside SEND_A/SEND_B: in_data=0, col_end=0, row_end=0.
- Illegal dimensions (a_cols != b_rows) are still streamed unchanged.
- Collection (WAIT_BUSY and COLLECT, on every mm_valid=1 cycle):
  - If mm_is_legal=0: set illegal and store nothing.
  - Otherwise: store mm_out_data at res_count, then increment res_count (saturating at 16). If mm_overflow=1, also set ovf_seen.
  - mm_change_row=1 increments rows_seen, saturating at 7.
- Completion check on entering DONE: count_err=1 when illegal=0, timeout=0 and res_count != a_rows*b_cols.
- Reset mid-run: returns to IDLE immediately. Streaming outputs go to 0 asynchronously.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], 2x2 each, with a cycle-accurate multiplier model -> stream 1,2,3,4,5,6,7,8; col_end on elements 2,4,6,8; row_end on 4 and 8 only; buffer={19,22,43,50}; res_count=4; all flags 0; done pulses once.
- A 2x3, B 2x2 -> both matrices streamed (6+4 elements); model answers is_legal=0 with valid=1 -> illegal=1, res_count=0, count_err=0.
- 4x4 A all 127, B all 127 -> 127*127*4 = 64516 exceeds RW -> ovf_seen=1 and res_count=16.
- mm_busy held 0 after the last B element -> timeout=1 exactly BUSY_TO cycles later; done pulses; host_busy falls.
- Model drops one result on 1x1 x 1x3 (expected 3) -> res_count=2, count_err=1.
- Assert rst during SEND_B -> in_data/col_end/row_end=0 immediately; after release, a new start with A=[[-2]], B=[[3]] -> buffer[0]=-6 (0xFFA).
